// File: rtl/rx_emb_ingress_if.sv
// rx_emb_ingress_if
//   Bundles the rx XGMII word stream, the parser side-band, the TSU config and
//   the reconstructed output stream of the ingress-time embedding stage.
//   slave  : the embedding block (samples *_i, drives *_o)
//   master : the surrounding environment (drives *_i, samples *_o)
interface rx_emb_ingress_if #(
  parameter int CNT_W = 11
) ();
  logic             rx_clk_en_i;
  logic [63:0]      rxd_i;
  logic [7:0]       rxc_i;
  logic [31:0]      tsu_cfg_i;
  logic [79:0]      sfd_timestamp_i;
  logic             ptp_info_vld_i;
  logic             is_ptp_message_i;
  logic [3:0]       ptp_messageType_i;
  logic [CNT_W-1:0] ptp_addr_base_i;
  logic             ipv4_flag_i;
  logic [CNT_W-1:0] ipv4_addr_base_i;
  logic [63:0]      rxd_o;
  logic [7:0]       rxc_o;
  logic             rpl_crc_o;
  logic [31:0]      ingress_time_o;

  modport slave (
    input  rx_clk_en_i, rxd_i, rxc_i, tsu_cfg_i, sfd_timestamp_i,
           ptp_info_vld_i, is_ptp_message_i, ptp_messageType_i,
           ptp_addr_base_i, ipv4_flag_i, ipv4_addr_base_i,
    output rxd_o, rxc_o, rpl_crc_o, ingress_time_o
  );

  modport master (
    output rx_clk_en_i, rxd_i, rxc_i, tsu_cfg_i, sfd_timestamp_i,
           ptp_info_vld_i, is_ptp_message_i, ptp_messageType_i,
           ptp_addr_base_i, ipv4_flag_i, ipv4_addr_base_i,
    input  rxd_o, rxc_o, rpl_crc_o, ingress_time_o
  );
endinterface

// File: rtl/rx_emb_ingress.sv
// rx_emb_ingress
//   Rx-path PTP frame reconstruction. Delays the XGMII word stream by DLY
//   words, then at the insertion stage writes the 32-bit ingress nanoseconds
//   into the PTP header reserved field (ptp_base+16..19) of event messages,
//   zeroes the UDP checksum (ipv4_base+26..27) of IPv4 frames it changes, and
//   raises rpl_crc_o on every word of a modified frame. Latency is DLY+1
//   enabled cycles.
// Ports
//   rx_clk, rx_rst : clock, asynchronous active-high reset
//   bus (slave)    : rx words in/out, clock enable, config, SFD timestamp,
//                    parser side-band, rpl_crc_o, ingress_time_o
module rx_emb_ingress #(
  parameter int DLY   = 8,
  parameter int CNT_W = 11
) (
  input logic             rx_clk,
  input logic             rx_rst,
  rx_emb_ingress_if.slave bus
);
  localparam logic [63:0]      IDLE_D   = 64'h0707070707070707;
  localparam logic [7:0]       IDLE_C   = 8'hFF;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam int               AGE_W    = $clog2(DLY + 2);
  localparam logic [AGE_W-1:0] AGE_NONE = AGE_W'(DLY + 1);

  typedef enum logic {IDLE, FRAME} state_t;
  typedef logic [CNT_W:0] addr_t;
  typedef struct packed {
    logic             vld;
    logic             ptp;
    logic [3:0]       mtype;
    logic [CNT_W-1:0] pb;
    logic             ip;
    logic [CNT_W-1:0] ib;
  } info_t;

  logic             en;
  logic             start_in;
  info_t            live_info;
  logic [63:0]      dly_d    [DLY];
  logic [7:0]       dly_c    [DLY];
  logic [31:0]      dly_ts   [DLY];
  info_t            dly_info [DLY];
  logic [AGE_W-1:0] age_q;

  logic [63:0]      stg_d;
  logic [7:0]       stg_c;
  logic             stg_start;
  logic             stg_term;
  info_t            snap;

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt, cur_cnt;
  info_t            ctx_q, ctx_nxt;
  logic             ctx_en_q, ctx_en_nxt;
  logic [63:0]      out_d_q, d_nxt;
  logic [7:0]       out_c_q;
  logic             rpl_q;
  logic [31:0]      time_q, time_nxt;
  logic             act, mod;
  addr_t            addr, sum;
  logic             unused_bits;

  assign en        = bus.rx_clk_en_i;
  assign start_in  = bus.rxc_i[0] & (bus.rxd_i[7:0] == 8'hFB);
  assign live_info = {1'b1, bus.is_ptp_message_i, bus.ptp_messageType_i,
                      bus.ptp_addr_base_i, bus.ipv4_flag_i, bus.ipv4_addr_base_i};
  assign unused_bits = ^{bus.tsu_cfg_i[31:6], bus.tsu_cfg_i[4:0], bus.sfd_timestamp_i[79:32]};

  // Delay line. Timestamp and parser info travel alongside the data so each
  // frame keeps its own context even when the next start word enters before
  // this one reaches the insertion stage. age_q counts enabled cycles since
  // the last input start word; a parser pulse is written into the stage the
  // start word is moving into, so later pulses simply overwrite it.
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      for (int k = 0; k < DLY; k++) begin
        dly_d[k]    <= IDLE_D;
        dly_c[k]    <= IDLE_C;
        dly_ts[k]   <= '0;
        dly_info[k] <= '0;
      end
      age_q <= AGE_NONE;
    end else if (en) begin
      dly_d[0]    <= bus.rxd_i;
      dly_c[0]    <= bus.rxc_i;
      dly_ts[0]   <= start_in ? bus.sfd_timestamp_i[31:0] : 32'h0;
      dly_info[0] <= (start_in && bus.ptp_info_vld_i) ? live_info : '0;
      for (int k = 1; k < DLY; k++) begin
        dly_d[k]    <= dly_d[k-1];
        dly_c[k]    <= dly_c[k-1];
        dly_ts[k]   <= dly_ts[k-1];
        dly_info[k] <= (bus.ptp_info_vld_i && !start_in && age_q == AGE_W'(k))
                       ? live_info : dly_info[k-1];
      end
      if (start_in) age_q <= AGE_W'(1);
      else if (age_q != AGE_NONE) age_q <= age_q + AGE_W'(1);
    end
  end

  assign stg_d     = dly_d[DLY-1];
  assign stg_c     = dly_c[DLY-1];
  assign stg_start = stg_c[0] & (stg_d[7:0] == 8'hFB);

  // A pulse exactly DLY cycles after the start word arrives while that word
  // is already at the insertion stage, so it bypasses the delay line.
  assign snap = (bus.ptp_info_vld_i && !start_in && age_q == AGE_W'(DLY))
                ? live_info : dly_info[DLY-1];

  always_comb begin
    stg_term = 1'b0;
    for (int i = 0; i < 8; i++)
      if (stg_c[i] && stg_d[8*i +: 8] == 8'hFD) stg_term = 1'b1;
  end

  // Insertion-stage FSM and byte editing. A start word always opens a fresh
  // context, which also aborts any frame still in progress. The counter
  // saturates, and a saturated counter disables all address matches.
  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    ctx_nxt    = ctx_q;
    ctx_en_nxt = ctx_en_q;
    time_nxt   = time_q;
    cur_cnt    = cnt_q;
    d_nxt      = stg_d;
    act        = 1'b0;
    mod        = 1'b0;
    addr       = '0;
    sum        = '0;
    if (stg_start) begin
      act        = 1'b1;
      cur_cnt    = '0;
      ctx_nxt    = snap;
      ctx_en_nxt = bus.tsu_cfg_i[5];
      time_nxt   = dly_ts[DLY-1];
      state_nxt  = FRAME;
    end else if (state_q == FRAME) begin
      act = 1'b1;
    end
    mod = act & ctx_nxt.vld & ctx_nxt.ptp & ctx_en_nxt & (ctx_nxt.mtype < 4'd4);
    if (mod && cur_cnt != CNT_MAX) begin
      for (int i = 0; i < 8; i++) begin
        if (!stg_c[i]) begin
          addr = {1'b0, cur_cnt} + addr_t'(i);
          for (int k = 0; k < 4; k++)
            if (addr == {1'b0, ctx_nxt.pb} + addr_t'(16 + k))
              d_nxt[8*i +: 8] = time_nxt[8*(3-k) +: 8];
          if (ctx_nxt.ip && (addr == {1'b0, ctx_nxt.ib} + addr_t'(26) ||
                             addr == {1'b0, ctx_nxt.ib} + addr_t'(27)))
            d_nxt[8*i +: 8] = 8'h00;
        end
      end
    end
    if (act) begin
      sum     = {1'b0, cur_cnt} + addr_t'(8);
      cnt_nxt = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
      if (stg_term) state_nxt = IDLE;
    end
  end

  // State, context and output registers; reset drops the output to idle
  // immediately and discards any partial frame.
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ctx_q    <= '0;
      ctx_en_q <= 1'b0;
      out_d_q  <= IDLE_D;
      out_c_q  <= IDLE_C;
      rpl_q    <= 1'b0;
      time_q   <= '0;
    end else if (en) begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      ctx_q    <= ctx_nxt;
      ctx_en_q <= ctx_en_nxt;
      out_d_q  <= d_nxt;
      out_c_q  <= stg_c;
      rpl_q    <= mod;
      time_q   <= time_nxt;
    end
  end

  assign bus.rxd_o          = out_d_q;
  assign bus.rxc_o          = out_c_q;
  assign bus.rpl_crc_o      = rpl_q;
  assign bus.ingress_time_o = time_q;
endmodule
